// File: rtl/fetch_stage_control.sv
// fetch_stage_control
//   Stage-1 controller of the pipelined processor. Owns the PC and the IR1 pipeline
//   register, and feeds IR2 through IR2Load. Handles downstream stalls, taken-branch
//   redirect/flush and the STOP instruction. Only valid words or NOP bubbles
//   (opcode 4'b1111) reach the downstream stages.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   imem_data      in   instruction at address pc_out (combinational memory read)
//   stall_req      in   downstream hazard: hold PC and IR1 this cycle
//   branch_taken   in   redirect request from a later stage
//   branch_target  in   redirect address, valid while branch_taken=1
//   pc_out         out  current fetch address
//   ir1_out        out  IR1 contents presented to the IR2 register
//   IR2Load        out  load enable for IR2; 0 while stalled or in reset
//   halted         out  1 while in the HALT state
//   fetch_count    out  number of non-bubble words written into IR1 (saturating)
module fetch_stage_control #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall_req,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] ir1_out,
    output logic               IR2Load,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [3:0]         OpNop  = 4'b1111;
    localparam logic [3:0]         OpStop = 4'b0001;
    localparam logic [INSTR_W-1:0] Nop    = {{(INSTR_W-4){1'b0}}, OpNop};

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir1_q, ir1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            pc_q    <= '0;
            ir1_q   <= Nop;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir1_q   <= ir1_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir1_d   = ir1_q;
        cnt_d   = cnt_q;
        if (branch_taken) begin
            // Redirect wins over stall and HALT: a STOP fetched down the wrong path is squashed.
            pc_d    = branch_target;
            ir1_d   = Nop;
            state_d = StRun;
        end else if (stall_req) begin
            // Hold everything; a STOP presented now is refetched after the stall.
        end else if (state_q == StRun) begin
            pc_d  = pc_q + 1'b1;
            ir1_d = imem_data;
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
            if (imem_data[3:0] == OpStop) begin
                state_d = StHalt;
            end
        end else begin
            ir1_d = Nop;
        end
    end

    // Combinational; forced low while reset is asserted so IR2 sees no load during reset.
    assign IR2Load     = reset & (branch_taken | ~stall_req);
    assign pc_out      = pc_q;
    assign ir1_out     = ir1_q;
    assign halted      = (state_q == StHalt);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage_control.sv
module tb_fetch_stage_control;

    logic        clock;
    logic        reset;
    logic [7:0]  imem_data;
    logic        stall_req;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  pc_out;
    logic [7:0]  ir1_out;
    logic        IR2Load;
    logic        halted;
    logic [15:0] fetch_count;

    logic [7:0] mem [256];
    int n_checks;
    int n_fail;

    fetch_stage_control #(
        .PC_W(8),
        .INSTR_W(8),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .imem_data(imem_data),
        .stall_req(stall_req),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .pc_out(pc_out),
        .ir1_out(ir1_out),
        .IR2Load(IR2Load),
        .halted(halted),
        .fetch_count(fetch_count)
    );

    assign imem_data = mem[pc_out];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        stall_req     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        reset         = 1'b0;
        #3;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (pc_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_pc actual=%h required=00", pc_out);
        end
        n_checks++;
        if (ir1_out !== 8'h0F) begin
            n_fail++; $display("FAIL reset_ir1 actual=%h required=0f", ir1_out);
        end
        n_checks++;
        if (halted !== 1'b0 || fetch_count !== 16'h0 || IR2Load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_misc actual=h%b c%h l%b required=h0 c0000 l0",
                     halted, fetch_count, IR2Load);
        end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_free_run();
        logic [7:0] exp [4];
        exp[0] = 8'h02; exp[1] = 8'h12; exp[2] = 8'h27; exp[3] = 8'h0F;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (ir1_out !== exp[i]) begin
                n_fail++; $display("FAIL run_ir1[%0d] actual=%h required=%h", i, ir1_out, exp[i]);
            end
        end
        n_checks++;
        if (pc_out !== 8'h04 || fetch_count !== 16'd4) begin
            n_fail++;
            $display("FAIL run_pc_cnt actual=%h/%0d required=04/4", pc_out, fetch_count);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        tick();
        tick();
        stall_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (IR2Load !== 1'b0) begin
                n_fail++; $display("FAIL stall_ir2load[%0d] actual=%b required=0", i, IR2Load);
            end
            tick();
            n_checks++;
            if (pc_out !== 8'h02 || ir1_out !== 8'h12 || fetch_count !== 16'd2) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] actual=%h/%h/%0d required=02/12/2",
                         i, pc_out, ir1_out, fetch_count);
            end
        end
        stall_req = 1'b0;
        tick();
        n_checks++;
        if (ir1_out !== 8'h27 || pc_out !== 8'h03) begin
            n_fail++; $display("FAIL stall_resume actual=%h/%h required=27/03", ir1_out, pc_out);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        tick();
        stall_req     = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        #1;
        n_checks++;
        if (IR2Load !== 1'b1) begin
            n_fail++; $display("FAIL branch_ir2load actual=%b required=1", IR2Load);
        end
        tick();
        stall_req    = 1'b0;
        branch_taken = 1'b0;
        n_checks++;
        if (pc_out !== 8'h40 || ir1_out !== 8'h0F || fetch_count !== 16'd1) begin
            n_fail++;
            $display("FAIL branch_bubble actual=%h/%h/%0d required=40/0f/1",
                     pc_out, ir1_out, fetch_count);
        end
        tick();
        n_checks++;
        if (ir1_out !== 8'h35 || pc_out !== 8'h41) begin
            n_fail++; $display("FAIL branch_target actual=%h/%h required=35/41", ir1_out, pc_out);
        end
    endtask

    task automatic test_stop();
        mem[5] = 8'h01;
        apply_reset();
        for (int i = 0; i < 5; i++) tick();
        // STOP presented during a stall must not be captured.
        stall_req = 1'b1;
        tick();
        stall_req = 1'b0;
        n_checks++;
        if (halted !== 1'b0 || ir1_out !== 8'h23) begin
            n_fail++; $display("FAIL stop_stalled actual=h%b/%h required=h0/23", halted, ir1_out);
        end
        tick();
        n_checks++;
        if (ir1_out !== 8'h01 || halted !== 1'b1 || pc_out !== 8'h06 || fetch_count !== 16'd6) begin
            n_fail++;
            $display("FAIL stop_enter actual=%h/h%b/%h/%0d required=01/h1/06/6",
                     ir1_out, halted, pc_out, fetch_count);
        end
        tick();
        tick();
        n_checks++;
        if (ir1_out !== 8'h0F || halted !== 1'b1 || pc_out !== 8'h06 || fetch_count !== 16'd6) begin
            n_fail++;
            $display("FAIL stop_frozen actual=%h/h%b/%h/%0d required=0f/h1/06/6",
                     ir1_out, halted, pc_out, fetch_count);
        end
        branch_taken  = 1'b1;
        branch_target = 8'h10;
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if (halted !== 1'b0 || pc_out !== 8'h10 || ir1_out !== 8'h0F) begin
            n_fail++;
            $display("FAIL stop_exit actual=h%b/%h/%h required=h0/10/0f", halted, pc_out, ir1_out);
        end
        mem[5] = 8'h02;
    endtask

    task automatic test_async_reset_in_halt();
        mem[5] = 8'h01;
        apply_reset();
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre actual=%b required=1", halted);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (pc_out !== 8'h00 || ir1_out !== 8'h0F || halted !== 1'b0 || fetch_count !== 16'h0
            || IR2Load !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_vals actual=%h/%h/h%b/%h/l%b required=00/0f/h0/0000/l0",
                     pc_out, ir1_out, halted, fetch_count, IR2Load);
        end
        reset = 1'b1;
        mem[5] = 8'h02;
        tick();
        n_checks++;
        if (ir1_out !== 8'h02 || pc_out !== 8'h01) begin
            n_fail++; $display("FAIL areset_first actual=%h/%h required=02/01", ir1_out, pc_out);
        end
    endtask

    task automatic test_wrap_saturate();
        apply_reset();
        branch_taken  = 1'b1;
        branch_target = 8'hFF;
        tick();
        branch_taken = 1'b0;
        tick();
        n_checks++;
        if (pc_out !== 8'h00 || ir1_out !== 8'h5A) begin
            n_fail++; $display("FAIL pc_wrap actual=%h/%h required=00/5a", pc_out, ir1_out);
        end
        apply_reset();
        for (int i = 0; i < 65534; i++) tick();
        n_checks++;
        if (fetch_count !== 16'hFFFE) begin
            n_fail++; $display("FAIL cnt_pre actual=%h required=fffe", fetch_count);
        end
        tick();
        n_checks++;
        if (fetch_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL cnt_max actual=%h required=ffff", fetch_count);
        end
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (fetch_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL cnt_sat actual=%h required=ffff", fetch_count);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        stall_req     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h02;
        mem[0]    = 8'h02;
        mem[1]    = 8'h12;
        mem[2]    = 8'h27;
        mem[3]    = 8'h0F;
        mem[4]    = 8'h23;
        mem[8'h40] = 8'h35;
        mem[8'hFF] = 8'h5A;
        #12;
        reset = 1'b1;

        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_stop();
        test_async_reset_in_halt();
        test_wrap_saturate();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
